// File: rtl/id_ex_if.sv
// Decode-to-execute bundle: decoded control word and operands (id_*)
// and their registered EX-stage copies (ex_*).
interface id_ex_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALU_CTRL_WIDTH = 5
);
    logic                      id_load_upper;
    logic [1:0]                id_jump;
    logic                      id_jal;
    logic                      id_reg_write;
    logic                      id_mem_to_reg;
    logic                      id_mem_write;
    logic [ALU_CTRL_WIDTH-1:0] id_alu_control;
    logic                      id_alu_src;
    logic                      id_reg_dst;
    logic                      id_branch;
    logic [3:0]                id_bcu_control;
    logic [DATA_WIDTH-1:0]     id_pc_plus4;
    logic [DATA_WIDTH-1:0]     id_rs_data;
    logic [DATA_WIDTH-1:0]     id_rt_data;
    logic [DATA_WIDTH-1:0]     id_imm;
    logic [REG_ADDR_WIDTH-1:0] id_rs;
    logic [REG_ADDR_WIDTH-1:0] id_rt;
    logic [REG_ADDR_WIDTH-1:0] id_rd;

    logic                      ex_load_upper;
    logic [1:0]                ex_jump;
    logic                      ex_jal;
    logic                      ex_reg_write;
    logic                      ex_mem_to_reg;
    logic                      ex_mem_write;
    logic [ALU_CTRL_WIDTH-1:0] ex_alu_control;
    logic                      ex_alu_src;
    logic                      ex_reg_dst;
    logic                      ex_branch;
    logic [3:0]                ex_bcu_control;
    logic [DATA_WIDTH-1:0]     ex_pc_plus4;
    logic [DATA_WIDTH-1:0]     ex_rs_data;
    logic [DATA_WIDTH-1:0]     ex_rt_data;
    logic [DATA_WIDTH-1:0]     ex_imm;
    logic [REG_ADDR_WIDTH-1:0] ex_rs;
    logic [REG_ADDR_WIDTH-1:0] ex_rt;
    logic [REG_ADDR_WIDTH-1:0] ex_rd;
    logic                      ex_valid;

    modport master (
        output id_load_upper, id_jump, id_jal, id_reg_write,
               id_mem_to_reg, id_mem_write, id_alu_control,
               id_alu_src, id_reg_dst, id_branch, id_bcu_control,
               id_pc_plus4, id_rs_data, id_rt_data, id_imm,
               id_rs, id_rt, id_rd,
        input  ex_load_upper, ex_jump, ex_jal, ex_reg_write,
               ex_mem_to_reg, ex_mem_write, ex_alu_control,
               ex_alu_src, ex_reg_dst, ex_branch, ex_bcu_control,
               ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_rd, ex_valid
    );

    modport slave (
        input  id_load_upper, id_jump, id_jal, id_reg_write,
               id_mem_to_reg, id_mem_write, id_alu_control,
               id_alu_src, id_reg_dst, id_branch, id_bcu_control,
               id_pc_plus4, id_rs_data, id_rt_data, id_imm,
               id_rs, id_rt, id_rd,
        output ex_load_upper, ex_jump, ex_jal, ex_reg_write,
               ex_mem_to_reg, ex_mem_write, ex_alu_control,
               ex_alu_src, ex_reg_dst, ex_branch, ex_bcu_control,
               ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_rd, ex_valid
    );
endinterface

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use bubble insertion, stall/flush
// control and a saturating count of inserted bubbles.
module id_ex_register #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALU_CTRL_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    id_ex_if.slave               bus,
    output logic                 id_hold,
    output logic                 load_use_bubble,
    output logic [CNT_WIDTH-1:0] bubble_count
);
    typedef struct packed {
        logic                      load_upper;
        logic [1:0]                jump;
        logic                      jal;
        logic                      reg_write;
        logic                      mem_to_reg;
        logic                      mem_write;
        logic [ALU_CTRL_WIDTH-1:0] alu_control;
        logic                      alu_src;
        logic                      reg_dst;
        logic                      branch;
        logic [3:0]                bcu_control;
        logic [DATA_WIDTH-1:0]     pc_plus4;
        logic [DATA_WIDTH-1:0]     rs_data;
        logic [DATA_WIDTH-1:0]     rt_data;
        logic [DATA_WIDTH-1:0]     imm;
        logic [REG_ADDR_WIDTH-1:0] rs;
        logic [REG_ADDR_WIDTH-1:0] rt;
        logic [REG_ADDR_WIDTH-1:0] rd;
    } id_ex_t;

    id_ex_t               r_ex;
    logic                 r_valid;
    logic [CNT_WIDTH-1:0] r_count;
    id_ex_t               w_id;
    logic                 w_hazard;
    logic                 w_rs_match;
    logic                 w_rt_match;

    assign w_id = '{
        load_upper:  bus.id_load_upper,
        jump:        bus.id_jump,
        jal:         bus.id_jal,
        reg_write:   bus.id_reg_write,
        mem_to_reg:  bus.id_mem_to_reg,
        mem_write:   bus.id_mem_write,
        alu_control: bus.id_alu_control,
        alu_src:     bus.id_alu_src,
        reg_dst:     bus.id_reg_dst,
        branch:      bus.id_branch,
        bcu_control: bus.id_bcu_control,
        pc_plus4:    bus.id_pc_plus4,
        rs_data:     bus.id_rs_data,
        rt_data:     bus.id_rt_data,
        imm:         bus.id_imm,
        rs:          bus.id_rs,
        rt:          bus.id_rt,
        rd:          bus.id_rd
    };

    // rt only counts as a source when the ALU is not taking the immediate
    assign w_rs_match = (r_ex.rt == bus.id_rs);
    assign w_rt_match = (r_ex.rt == bus.id_rt) & ~bus.id_alu_src;
    assign w_hazard   = r_valid & r_ex.mem_to_reg
                      & (r_ex.rt != '0)
                      & (w_rs_match | w_rt_match);

    assign load_use_bubble = w_hazard;
    assign id_hold         = stall | (w_hazard & ~flush);
    assign bubble_count    = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex    <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
        end else if (flush) begin
            r_ex    <= '0;
            r_valid <= 1'b0;
        end else if (stall) begin
            r_ex    <= r_ex;
            r_valid <= r_valid;
        end else if (w_hazard) begin
            r_ex    <= '0;
            r_valid <= 1'b0;
            if (r_count != '1)
                r_count <= r_count + 1'b1;
        end else begin
            r_ex    <= w_id;
            r_valid <= 1'b1;
        end
    end

    assign bus.ex_load_upper  = r_ex.load_upper;
    assign bus.ex_jump        = r_ex.jump;
    assign bus.ex_jal         = r_ex.jal;
    assign bus.ex_reg_write   = r_ex.reg_write;
    assign bus.ex_mem_to_reg  = r_ex.mem_to_reg;
    assign bus.ex_mem_write   = r_ex.mem_write;
    assign bus.ex_alu_control = r_ex.alu_control;
    assign bus.ex_alu_src     = r_ex.alu_src;
    assign bus.ex_reg_dst     = r_ex.reg_dst;
    assign bus.ex_branch      = r_ex.branch;
    assign bus.ex_bcu_control = r_ex.bcu_control;
    assign bus.ex_pc_plus4    = r_ex.pc_plus4;
    assign bus.ex_rs_data     = r_ex.rs_data;
    assign bus.ex_rt_data     = r_ex.rt_data;
    assign bus.ex_imm         = r_ex.imm;
    assign bus.ex_rs          = r_ex.rs;
    assign bus.ex_rt          = r_ex.rt;
    assign bus.ex_rd          = r_ex.rd;
    assign bus.ex_valid       = r_valid;
endmodule

// File: tb/tb_id_ex_register.sv
// Directed bench for id_ex_register; small counter width so saturation
// is reachable in a few dozen cycles.
module tb_id_ex_register;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 5;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall;
    logic          flush;
    logic          id_hold;
    logic          load_use_bubble;
    logic [NW-1:0] bubble_count;
    int            n_checks = 0;
    int            n_fails  = 0;

    id_ex_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW),
               .ALU_CTRL_WIDTH(CW)) bus ();

    id_ex_register #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW),
        .ALU_CTRL_WIDTH(CW), .CNT_WIDTH(NW)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .bus(bus), .id_hold(id_hold),
        .load_use_bubble(load_use_bubble),
        .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_clear();
        bus.id_load_upper  = 0; bus.id_jump     = 0;
        bus.id_jal         = 0; bus.id_reg_write = 0;
        bus.id_mem_to_reg  = 0; bus.id_mem_write = 0;
        bus.id_alu_control = 0; bus.id_alu_src   = 0;
        bus.id_reg_dst     = 0; bus.id_branch    = 0;
        bus.id_bcu_control = 0; bus.id_pc_plus4  = 0;
        bus.id_rs_data     = 0; bus.id_rt_data   = 0;
        bus.id_imm         = 0; bus.id_rs        = 0;
        bus.id_rt          = 0; bus.id_rd        = 0;
    endtask

    // load word: rt is the destination, base in rs, immediate operand
    task automatic id_load(input logic [AW-1:0] rs,
                           input logic [AW-1:0] rt);
        id_clear();
        bus.id_mem_to_reg = 1; bus.id_reg_write = 1;
        bus.id_alu_src    = 1; bus.id_rs        = rs;
        bus.id_rt         = rt; bus.id_imm      = 32'h10;
    endtask

    task automatic test_reset();
        reset = 1; stall = 0; flush = 0;
        bus.id_load_upper  = 1; bus.id_jump = 2'b10;
        bus.id_reg_write   = 1; bus.id_mem_to_reg = 1;
        bus.id_mem_write   = 1; bus.id_alu_control = 5'h1b;
        bus.id_branch      = 1; bus.id_pc_plus4 = $urandom;
        bus.id_rs_data     = $urandom; bus.id_rt_data = $urandom;
        bus.id_imm         = $urandom; bus.id_rs = 5'd7;
        bus.id_rt          = 5'd8; bus.id_rd = 5'd9;
        tick(); tick();
        n_checks++;
        if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0 ||
            bus.ex_mem_write !== 1'b0 || bus.ex_jump !== 2'b00) begin
            n_fails++;
            $display("FAIL reset_ctrl got v=%b rw=%b mw=%b j=%b exp 0",
                     bus.ex_valid, bus.ex_reg_write,
                     bus.ex_mem_write, bus.ex_jump);
        end
        n_checks++;
        if (bus.ex_rs_data !== 0 || bus.ex_pc_plus4 !== 0 ||
            bus.ex_rt !== 0 || bus.ex_imm !== 0) begin
            n_fails++;
            $display("FAIL reset_data got rs_data=%h pc=%h rt=%h imm=%h exp 0",
                     bus.ex_rs_data, bus.ex_pc_plus4,
                     bus.ex_rt, bus.ex_imm);
        end
        n_checks++;
        if (bubble_count !== 4'd0) begin
            n_fails++;
            $display("FAIL reset_count got %0d exp 0", bubble_count);
        end
        reset = 0;
        id_clear();
    endtask

    task automatic test_pass_through();
        id_clear();
        bus.id_reg_write = 1; bus.id_alu_control = 5'h02;
        bus.id_rs_data = 32'h1234; bus.id_pc_plus4 = 32'h100;
        bus.id_rd = 5'd3; bus.id_bcu_control = 4'h9;
        tick();
        n_checks++;
        if (bus.ex_reg_write !== 1'b1 || bus.ex_alu_control !== 5'h02 ||
            bus.ex_rs_data !== 32'h1234 || bus.ex_valid !== 1'b1) begin
            n_fails++;
            $display("FAIL pass_through got rw=%b alu=%h rs_data=%h v=%b exp 1 02 1234 1",
                     bus.ex_reg_write, bus.ex_alu_control,
                     bus.ex_rs_data, bus.ex_valid);
        end
        n_checks++;
        if (bus.ex_pc_plus4 !== 32'h100 || bus.ex_rd !== 5'd3 ||
            bus.ex_bcu_control !== 4'h9) begin
            n_fails++;
            $display("FAIL pass_fields got pc=%h rd=%0d bcu=%h exp 100 3 9",
                     bus.ex_pc_plus4, bus.ex_rd, bus.ex_bcu_control);
        end
    endtask

    task automatic test_load_use();
        id_load(5'd1, 5'd8);
        tick();
        id_clear();
        bus.id_rs = 5'd8; bus.id_rt = 5'd9;
        bus.id_rs_data = 32'haaaa; bus.id_reg_write = 1;
        #1;
        n_checks++;
        if (load_use_bubble !== 1'b1 || id_hold !== 1'b1) begin
            n_fails++;
            $display("FAIL load_use_detect got bubble=%b hold=%b exp 1 1",
                     load_use_bubble, id_hold);
        end
        tick();
        n_checks++;
        if (bus.ex_valid !== 1'b0 || bus.ex_mem_to_reg !== 1'b0 ||
            bubble_count !== 4'd1) begin
            n_fails++;
            $display("FAIL load_use_bubble got v=%b m2r=%b cnt=%0d exp 0 0 1",
                     bus.ex_valid, bus.ex_mem_to_reg, bubble_count);
        end
        n_checks++;
        if (load_use_bubble !== 1'b0 || id_hold !== 1'b0) begin
            n_fails++;
            $display("FAIL load_use_release got bubble=%b hold=%b exp 0 0",
                     load_use_bubble, id_hold);
        end
        tick();
        n_checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_rs !== 5'd8 ||
            bus.ex_rs_data !== 32'haaaa) begin
            n_fails++;
            $display("FAIL load_use_capture got v=%b rs=%0d rs_data=%h exp 1 8 aaaa",
                     bus.ex_valid, bus.ex_rs, bus.ex_rs_data);
        end
    endtask

    task automatic test_no_false_hazard();
        id_load(5'd2, 5'd0);
        tick();
        id_clear();
        bus.id_rs = 5'd0; bus.id_rt = 5'd0;
        #1;
        n_checks++;
        if (load_use_bubble !== 1'b0) begin
            n_fails++;
            $display("FAIL no_hazard_r0 got %b exp 0", load_use_bubble);
        end
        id_load(5'd1, 5'd8);
        tick();
        id_clear();
        bus.id_rs = 5'd2; bus.id_rt = 5'd8; bus.id_alu_src = 1;
        #1;
        n_checks++;
        if (load_use_bubble !== 1'b0 || id_hold !== 1'b0) begin
            n_fails++;
            $display("FAIL no_hazard_imm got bubble=%b hold=%b exp 0 0",
                     load_use_bubble, id_hold);
        end
        bus.id_alu_src = 0;
        #1;
        n_checks++;
        if (load_use_bubble !== 1'b1) begin
            n_fails++;
            $display("FAIL hazard_rt got %b exp 1", load_use_bubble);
        end
        bus.id_alu_src = 1;
        tick();
        n_checks++;
        if (bus.ex_valid !== 1'b1 || bubble_count !== 4'd1) begin
            n_fails++;
            $display("FAIL no_hazard_capture got v=%b cnt=%0d exp 1 1",
                     bus.ex_valid, bubble_count);
        end
    endtask

    task automatic test_stall_flush();
        id_clear();
        bus.id_rs_data = 32'h5555; bus.id_reg_write = 1;
        tick();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            bus.id_rs_data = 32'h6000 + i;
            bus.id_reg_write = 0;
            tick();
            n_checks++;
            if (bus.ex_rs_data !== 32'h5555 || bus.ex_valid !== 1'b1 ||
                bus.ex_reg_write !== 1'b1 || id_hold !== 1'b1) begin
                n_fails++;
                $display("FAIL stall_hold[%0d] got rs_data=%h v=%b rw=%b hold=%b exp 5555 1 1 1",
                         i, bus.ex_rs_data, bus.ex_valid,
                         bus.ex_reg_write, id_hold);
            end
        end
        flush = 1;
        tick();
        n_checks++;
        if (bus.ex_valid !== 1'b0 || bus.ex_rs_data !== 0 ||
            bus.ex_reg_write !== 1'b0) begin
            n_fails++;
            $display("FAIL stall_flush got v=%b rs_data=%h rw=%b exp 0 0 0",
                     bus.ex_valid, bus.ex_rs_data, bus.ex_reg_write);
        end
        stall = 0; flush = 0;
        // flush beats a pending load-use hazard and does not count it
        id_load(5'd1, 5'd8);
        tick();
        id_clear();
        bus.id_rs = 5'd8; bus.id_rs_data = 32'h77;
        flush = 1;
        #1;
        n_checks++;
        if (load_use_bubble !== 1'b1 || id_hold !== 1'b0) begin
            n_fails++;
            $display("FAIL flush_hold got bubble=%b hold=%b exp 1 0",
                     load_use_bubble, id_hold);
        end
        tick();
        flush = 0;
        n_checks++;
        if (bus.ex_valid !== 1'b0 || bubble_count !== 4'd1) begin
            n_fails++;
            $display("FAIL flush_hazard got v=%b cnt=%0d exp 0 1",
                     bus.ex_valid, bubble_count);
        end
        // stall with a hazard pending: hold, no count
        id_load(5'd1, 5'd8);
        tick();
        id_clear();
        bus.id_rs = 5'd8;
        stall = 1;
        tick();
        stall = 0;
        n_checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_rt !== 5'd8 ||
            bubble_count !== 4'd1) begin
            n_fails++;
            $display("FAIL stall_hazard got v=%b rt=%0d cnt=%0d exp 1 8 1",
                     bus.ex_valid, bus.ex_rt, bubble_count);
        end
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        // entry: count is 2 after the bubble at the end of the stall test
        id_load(5'd1, 5'd8);
        tick();
        id_load(5'd8, 5'd9);
        tick();
        tick();
        n_checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_rt !== 5'd9 ||
            bubble_count !== 4'd3) begin
            n_fails++;
            $display("FAIL b2b_first got v=%b rt=%0d cnt=%0d exp 1 9 3",
                     bus.ex_valid, bus.ex_rt, bubble_count);
        end
        id_clear();
        bus.id_rs = 5'd9;
        tick();
        tick();
        n_checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_rs !== 5'd9 ||
            bubble_count !== 4'd4) begin
            n_fails++;
            $display("FAIL b2b_second got v=%b rs=%0d cnt=%0d exp 1 9 4",
                     bus.ex_valid, bus.ex_rs, bubble_count);
        end
    endtask

    task automatic test_reset_mid_hazard();
        id_load(5'd1, 5'd8);
        tick();
        id_clear();
        bus.id_rs = 5'd8;
        stall = 1; reset = 1;
        tick();
        stall = 0; reset = 0;
        n_checks++;
        if (bus.ex_valid !== 1'b0 || bus.ex_mem_to_reg !== 1'b0 ||
            bubble_count !== 4'd0) begin
            n_fails++;
            $display("FAIL reset_mid_hazard got v=%b m2r=%b cnt=%0d exp 0 0 0",
                     bus.ex_valid, bus.ex_mem_to_reg, bubble_count);
        end
    endtask

    task automatic test_saturation();
        id_load(5'd8, 5'd8);
        tick();
        for (int i = 0; i < 15; i++) begin
            tick();
            tick();
        end
        n_checks++;
        if (bubble_count !== 4'hf) begin
            n_fails++;
            $display("FAIL sat_reach got %0d exp 15", bubble_count);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tick();
        end
        n_checks++;
        if (bubble_count !== 4'hf) begin
            n_fails++;
            $display("FAIL sat_hold got %0d exp 15", bubble_count);
        end
        id_clear();
    endtask

    initial begin
        reset = 1; stall = 0; flush = 0;
        id_clear();
        test_reset();
        test_pass_through();
        test_load_use();
        test_no_false_hazard();
        test_stall_flush();
        test_back_to_back();
        test_reset_mid_hazard();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end
endmodule
